alu_share_arbiter: RTL and testbench

// - Shares one combinational Alu instance between NUM_REQ requesters
//   (e.g. execute stage, address generator, debug unit).
// - Round-robin arbitration picks at most one requester per cycle and drives the
//   Alu operand/oper bus.
// - The Alu result is registered into a one-entry response slot, tagged with the

---
 rtl/alu_share_arbiter_pkg.sv | 25 ++
 rtl/alu_share_arbiter_rr.sv | 36 +++
 rtl/alu_share_arbiter.sv | 106 ++++++++++
 tb/tb_alu_share_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: operation encoding, oper field type and arbiter limits.
// Also holds the response-slot state type used by the ALU share arbiter.
package alu_share_arbiter_pkg;

    localparam int ALU_OPER_W      = 4;
    localparam int ALU_ARB_MAX_REQ = 4;

    typedef logic [ALU_OPER_W-1:0] alu_oper_t;

    typedef enum alu_oper_t {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_NAND = 4'd6
    } alu_oper_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
// Reusable by any arbiter that keeps its own priority pointer.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap ptr+k back into 0..N-1 without a divider; works for non power-of-two N.
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin grant
// and a one-entry tagged response slot that can drain and refill in one cycle.
//
// state      | meaning
// SLOT_EMPTY | no response held, rsp_valid=0, any pending request may be granted
// SLOT_FULL  | response held for requester rsp_tag until its rsp_ready pops it
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int OPER_WIDTH = 4,
    localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*OPER_WIDTH-1:0]    req_oper,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
    output logic [OPER_WIDTH-1:0]            alu_oper,
    output logic [DATA_WIDTH-1:0]            alu_a,
    output logic [DATA_WIDTH-1:0]            alu_b,
    input  logic [DATA_WIDTH-1:0]            alu_data,
    output logic                             rsp_valid,
    output logic [TAG_W-1:0]                 rsp_tag,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    input  logic [NUM_REQ-1:0]               rsp_ready
);

    slot_state_e           state_q, state_d;
    logic [TAG_W-1:0]      tag_q;
    logic [TAG_W-1:0]      rr_ptr_q;
    logic [TAG_W-1:0]      win_idx;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_REQ-1:0]    gnt;
    logic                  pop;
    logic                  can_issue;
    logic                  any_gnt;

    // Only the owner's ready bit can release the slot.
    assign pop       = (state_q == SLOT_FULL) && rsp_ready[tag_q];
    assign can_issue = (state_q == SLOT_EMPTY) || pop;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (can_issue),
        .gnt (gnt)
    );

    assign any_gnt   = |gnt;
    assign req_ready = gnt;

    always_comb begin
        win_idx  = '0;
        alu_oper = OPER_WIDTH'(ALU_ADD);
        alu_a    = '0;
        alu_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx  = TAG_W'(i);
                alu_oper = req_oper[i*OPER_WIDTH +: OPER_WIDTH];
                alu_a    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                alu_b    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (any_gnt)         state_d = SLOT_FULL;
            SLOT_FULL:  if (pop && !any_gnt) state_d = SLOT_EMPTY;
            default:                         state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
        end else if (any_gnt) begin
            data_q   <= alu_data;
            tag_q    <= win_idx;
            rr_ptr_q <= (win_idx == TAG_W'(NUM_REQ-1)) ? '0 : win_idx + TAG_W'(1);
        end
    end

    assign rsp_valid = (state_q == SLOT_FULL);
    assign rsp_tag   = tag_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios plus random traffic
// checked against a cycle-level reference of grants and a queue of expected responses.
module tb_alu_share_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int OW = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*OW-1:0] req_oper;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [OW-1:0]   alu_oper;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_data;
    logic            rsp_valid;
    logic [0:0]      rsp_tag;
    logic [DW-1:0]   rsp_data;
    logic [N-1:0]    rsp_ready;

    alu_share_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .OPER_WIDTH (OW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_oper  (req_oper),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_oper  (alu_oper),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_data  (alu_data),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    function automatic logic [DW-1:0] alu_f(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ~(a & b);
            default: return '0;
        endcase
    endfunction

    assign alu_data = alu_f(alu_oper, alu_a, alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int            tag;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          q[$];
    int            gnt_log[$];
    int            checks   = 0;
    int            failures = 0;

    logic [N-1:0]  pend_v;
    logic [OW-1:0] pend_op[N];
    logic [DW-1:0] pend_a[N];
    logic [DW-1:0] pend_b[N];
    logic [N-1:0]  rdy;

    logic          m_full;
    int            m_tag;
    int            m_ptr;
    int            dut_g;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_full && !rdy[m_tag]) return -1;
        for (int k = 0; k < N; k++) begin
            if (pend_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(int i, logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        pend_v[i]  = 1'b1;
        pend_op[i] = op;
        pend_a[i]  = a;
        pend_b[i]  = b;
    endtask

    task automatic rand_req(int i);
        set_req(i, OW'($urandom_range(0, 6)), $urandom, $urandom);
    endtask

    // One clock cycle: drive, compare the grant against the reference, update the reference.
    task automatic cycle();
        int   g;
        rsp_t r;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_oper[i*OW +: OW] = pend_op[i];
            req_a[i*DW +: DW]    = pend_a[i];
            req_b[i*DW +: DW]    = pend_b[i];
        end
        req_valid = pend_v;
        rsp_ready = rdy;
        #2;
        g = model_grant();
        check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
        if (g < 0) begin
            check("alu_idle_bus", {alu_oper, alu_a, alu_b}, '0);
        end
        dut_g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_g = i;
        if (dut_g >= 0) gnt_log.push_back(dut_g);
        if (g >= 0) begin
            r.tag  = g;
            r.data = alu_f(pend_op[g], pend_a[g], pend_b[g]);
            q.push_back(r);
            m_full    = 1'b1;
            m_tag     = g;
            m_ptr     = (g + 1) % N;
            pend_v[g] = 1'b0;
        end else if (m_full && rdy[m_tag]) begin
            m_full = 1'b0;
        end
    endtask

    task automatic model_clear();
        q.delete();
        gnt_log.delete();
        m_full = 1'b0;
        m_tag  = 0;
        m_ptr  = 0;
        pend_v = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the expected owner accepts a response.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
                if (q.size() != 0 && rsp_ready[q[0].tag]) begin
                    e = q.pop_front();
                    check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_oper  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        rdy       = '0;
        for (int i = 0; i < N; i++) begin
            pend_op[i] = '0;
            pend_a[i]  = '0;
            pend_b[i]  = '0;
        end
        model_clear();
        #12;
        check("reset_state", {rsp_valid, rsp_tag, rsp_data}, '0);
        do_reset();

        // single op
        set_req(0, 4'd0, 32'd5, 32'd7);
        rdy = '0;
        cycle();
        check("single_grant", 64'(dut_g), 64'(0));
        cycle();
        check("single_rsp", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 1'b0, 32'd12});
        rdy = 2'b11;
        cycle();

        // contention from reset
        do_reset();
        set_req(0, 4'd1, 32'd10, 32'd3);
        set_req(1, 4'd4, 32'hF0, 32'hFF);
        rdy = 2'b11;
        cycle();
        check("contend_first", 64'(dut_g), 64'(0));
        cycle();
        check("contend_second", 64'(dut_g), 64'(1));
        check("contend_data0", 64'(rsp_data), 64'd7);
        cycle();
        check("contend_data1", {rsp_tag, rsp_data}, {1'b1, 32'h0F});

        // backpressure with slot owned by r1
        set_req(1, 4'd0, 32'd1, 32'd2);
        rdy = '0;
        cycle();
        set_req(0, 4'd0, 32'd4, 32'd4);
        repeat (3) begin
            cycle();
            check("bp_stall", {req_ready, rsp_data}, {2'b00, 32'd3});
        end
        rdy = 2'b10;
        cycle();
        check("bp_release", 64'(req_ready), 64'(2'b01));

        // wrong-owner ready: slot owned by r0
        set_req(1, 4'd3, 32'h0C, 32'h03);
        rdy = 2'b10;
        cycle();
        check("wrong_owner", {req_ready, rsp_valid}, {2'b00, 1'b1});
        rdy = 2'b11;
        cycle();
        check("wrong_owner_after", 64'(dut_g), 64'(1));
        cycle();

        // fairness
        gnt_log.delete();
        for (int c = 0; c < 40 && gnt_log.size() < 8; c++) begin
            for (int i = 0; i < N; i++) if (!pend_v[i]) rand_req(i);
            cycle();
        end
        check("fair_count", 64'(gnt_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) begin
            check("fair_order", 64'(gnt_log[k]), 64'(k % 2));
        end

        // idle gap does not rotate priority
        pend_v = '0;
        rdy    = 2'b11;
        cycle();
        rand_req(0);
        cycle();
        check("idle_first", 64'(dut_g), 64'(0));
        repeat (3) cycle();
        rand_req(0);
        rand_req(1);
        cycle();
        check("idle_after_gap", 64'(dut_g), 64'(1));
        cycle();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if (!pend_v[i] && $urandom_range(0, 1) == 1) rand_req(i);
            rdy = N'($urandom);
            cycle();
        end

        // async reset with a full slot
        pend_v = '0;
        rdy    = 2'b11;
        repeat (2) cycle();
        set_req(0, 4'd0, 32'hDEADBEEF, 32'd0);
        rdy = '0;
        cycle();
        cycle();
        check("pre_reset_full", {rsp_valid, rsp_data}, {1'b1, 32'hDEADBEEF});
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {rsp_valid, rsp_data}, {1'b0, 32'h0});
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        rand_req(0);
        rand_req(1);
        rdy = 2'b11;
        cycle();
        check("post_reset_grant", 64'(dut_g), 64'(0));

        pend_v = '0;
        repeat (3) cycle();
        check("drained", 64'(rsp_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
